// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the hazard scoreboard.
package hazard_pkg;

    localparam int NUM_REGS = 32;
    localparam int CNT_W    = 2;   // per-register forwarding countdown width
    localparam int LONG_W   = 3;   // outstanding long-op counter width

    // Latency class of the instruction being issued; RSVD behaves like ALU.
    typedef enum logic [1:0] {
        ALU  = 2'd0,
        LOAD = 2'd1,
        LONG = 2'd2,
        RSVD = 2'd3
    } lat_class_e;

endpackage

// File: rtl/sb_reg_entry.sv
// sb_reg_entry: scoreboard state for one architectural register.
// cnt counts cycles until a load result is forwardable; busy marks a pending
// long-unit write. An issue load beats the per-cycle decrement, and a busy set
// beats a busy clear, so the newest issue always defines the register state.
module sb_reg_entry
    import hazard_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    input  logic             set_i,
    input  logic             clr_i,
    output logic             busy_o,
    output logic             not_ready_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;

    // Next state: issue load over decrement, busy set over busy clear
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
        if (set_i) begin
            busy_d = 1'b1;
        end else if (clr_i) begin
            busy_d = 1'b0;
        end
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: this per-register array is reset because a reset must drop every pending hazard at once.
        if (!rst_ni) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy_o      = busy_q;
    assign not_ready_o = (cnt_q != '0) || busy_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: decides whether the operands of the instruction in ID
// exist yet (load results still in EX, pending long-unit writes) and stalls
// ID until they do. Also enforces the long-op limit and WAW on long results.
// Optional feature: define HAZARD_SB_STATS_EN to count stall cycles on
// stall_cnt_o; otherwise that port is tied to zero.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int LOAD_LAT = 1,
    parameter int MAX_LONG = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [4:0]  rs1_id_i,
    input  logic [4:0]  rs2_id_i,
    input  logic        use_rs1_i,
    input  logic        use_rs2_i,
    input  logic        issue_valid_i,
    input  logic        issue_reg_write_i,
    input  logic [4:0]  issue_rd_i,
    input  logic [1:0]  issue_class_i,
    input  logic        hold_i,
    input  logic        flush_i,
    input  logic        done_valid_i,
    input  logic [4:0]  done_rd_i,
    output logic        stall_o,
    output logic        issue_ok_o,
    output logic        err_o,
    output logic [31:0] stall_cnt_o
);

    localparam logic [CNT_W-1:0]  LOAD_VAL = CNT_W'(LOAD_LAT);
    localparam logic [LONG_W-1:0] LONG_LIM = LONG_W'(MAX_LONG);

    lat_class_e          issue_cls;
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] not_ready;
    logic [CNT_W-1:0]    issue_cnt;
    logic [LONG_W-1:0]   long_cnt_q, long_cnt_d, long_eff;
    logic                err_q, err_d;
    logic                done_dec_req, done_dec, done_err;
    logic                rs1_hz, rs2_hz, waw_hz, struct_hz;
    logic                wr_ok, long_issue;

    assign issue_cls = lat_class_e'(issue_class_i);
    assign issue_cnt = (issue_cls == LOAD) ? LOAD_VAL : '0;

    // x0 is hardwired zero and never produces a hazard
    assign busy[0]      = 1'b0;
    assign not_ready[0] = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
        logic hit_rd;
        assign hit_rd = wr_ok && (issue_rd_i == 5'(r));

        sb_reg_entry u_entry (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .load_i      (hit_rd && (issue_cls != LONG)),
            .load_val_i  (issue_cnt),
            .dec_i       (!hold_i),
            .set_i       (hit_rd && (issue_cls == LONG)),
            .clr_i       (done_valid_i && (done_rd_i == 5'(r))),
            .busy_o      (busy[r]),
            .not_ready_o (not_ready[r])
        );
    end

    // Completion bookkeeping: which dones retire a long op, which are spurious
    always_comb begin
        done_dec_req = done_valid_i && ((done_rd_i == '0) || busy[done_rd_i]);
        done_dec     = done_dec_req && (long_cnt_q != '0);
        done_err     = done_valid_i &&
                       (((done_rd_i != '0) && !busy[done_rd_i]) ||
                        (done_dec_req && (long_cnt_q == '0)));
        long_eff     = long_cnt_q - LONG_W'(done_dec);
    end

    // Hazard detection and issue decision for the instruction in ID
    always_comb begin
        rs1_hz     = use_rs1_i && not_ready[rs1_id_i];
        rs2_hz     = use_rs2_i && not_ready[rs2_id_i];
        waw_hz     = issue_reg_write_i && busy[issue_rd_i];
        struct_hz  = (issue_cls == LONG) && (long_eff == LONG_LIM);
        stall_o    = issue_valid_i && !flush_i && (rs1_hz || rs2_hz || waw_hz || struct_hz);
        issue_ok_o = issue_valid_i && !stall_o && !flush_i && !hold_i;
        wr_ok      = issue_ok_o && issue_reg_write_i && (issue_rd_i != '0);
        long_issue = issue_ok_o && (issue_cls == LONG);
    end

    // Long-op occupancy and sticky error next state
    always_comb begin
        long_cnt_d = long_cnt_q;
        if (long_issue && !done_dec) begin
            long_cnt_d = long_cnt_q + 1'b1;
        end else if (!long_issue && done_dec) begin
            long_cnt_d = long_cnt_q - 1'b1;
        end
        err_d = err_q || done_err;
    end

    // Long-op counter and error flag registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            long_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            long_cnt_q <= long_cnt_d;
            err_q      <= err_d;
        end
    end

    assign err_o = err_q;

`ifdef HAZARD_SB_STATS_EN
    logic [31:0] stall_cnt_q;

    // Saturating count of cycles in which ID really sat stalled
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
        end else if (stall_o && !hold_i && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Producer-side companion to the ALU bypass network. It tracks every in-flight register write whose result cannot yet be forwarded: load results still in EX, and multi-cycle MUL/DIV results. For the instruction in ID, it asserts a stall until every operand is forwardable. Sits in the ID stage beside the forwarding unit: forwarding selects *where* an operand comes from; this block decides *whether* it exists yet.

## Interface
Parameters:
- LOAD_LAT, 1: load-use stall cycles (1..3).
- MAX_LONG, 2: maximum outstanding long (multi-cycle) operations (1..7).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- rs1_id_i, rs2_id_i  in  5  source registers of the instruction in ID.
- use_rs1_i, use_rs2_i  in  1  the instruction in ID actually reads rs1 / rs2.
- issue_valid_i  in  1  the instruction in ID wants to move to EX.
- issue_reg_write_i  in  1  that instruction writes rd.
- issue_rd_i  in  5  its destination register.
- issue_class_i  in  2  lat_class_e: ALU, LOAD, LONG.
- hold_i  in  1  global pipeline freeze; all state holds.
- flush_i  in  1  squash ID; suppresses issue this cycle.
- done_valid_i  in  1  the long unit is writing back its result.
- done_rd_i  in  5  the register being written back.
- stall_o  out  1  hold ID/IF and inject a bubble into EX.
- issue_ok_o  out  1  issue accepted this cycle.
- err_o  out  1  sticky error: a done arrived for a register that was not busy.
- stall_cnt_o  out  32  stall cycle count (only with the macro; see Configuration).

## Operation
- Per-register state for x1..x31:
  - cnt[r], 2 bits: cycles until the value is forwardable.
  - busy[r], 1 bit: a long operation is pending.
  - x0 is never tracked.
- Long counter long_cnt, 3 bits: number of outstanding long operations.
- stall_o = !flush_i && issue_valid_i && any of the following:
  - (use_rs1_i && (cnt[rs1]!=0 || busy[rs1]));
  - the same condition for rs2;
  - WAW: issue_reg_write_i && busy[issue_rd_i];
  - structural: issue_class_i==LONG && long_cnt==MAX_LONG, after counting a same-cycle done.
- issue_ok_o = issue_valid_i && !stall_o && !flush_i && !hold_i.
- On issue_ok_o with issue_reg_write_i and rd!=0:
  - ALU: cnt[rd]=0 (EX forwarding covers it).
  - LOAD: cnt[rd]=LOAD_LAT.
  - LONG: busy[rd]=1 and long_cnt+1.
- A LONG op with rd==0 or no register write still increments long_cnt. The next done_valid_i decrements it, and busy is not touched.
- Every cycle with !hold_i, each nonzero cnt decrements by 1. This includes stall cycles, because the bubble still advances EX to MEM.
- done_valid_i with busy[done_rd_i]: clear busy and decrement long_cnt.
  - done_rd_i==0: long_cnt-1 only.
  - Not busy and rd!=0: set err_o; long_cnt is unchanged.
- done_valid_i is sampled even under hold_i, because the long unit runs independently.
- Simultaneous events:
  - A done and an issue to the same rd in one cycle: the issue state wins. WAW prevents this pairing with LONG.
  - long_cnt never wraps. A decrement at 0 sets err_o.

## Timing
- stall_o and issue_ok_o are combinational, with the same-cycle dependency on the ID inputs and the current state.
- State changes are visible the cycle after the edge.
- Load-use: with LOAD_LAT=1, a dependent issued the cycle after the load stalls exactly 1 cycle.
- A done in cycle N makes a dependent issue legal in cycle N+1. Forwarding supplies the data from WB.
- Reset values: every cnt=0, busy=0, long_cnt=0, err_o=0, stall_cnt_o=0. stall_o and issue_ok_o follow from the inputs.
- Reset mid-operation clears all pending state immediately (asynchronously). The long unit must be reset by the same rst_ni.

## Configuration
- HAZARD_SB_STATS_EN defined:
  - stall_cnt_o counts cycles with stall_o && !hold_i.
  - It saturates at 32'hFFFF_FFFF and resets to 0.
- HAZARD_SB_STATS_EN undefined:
  - The counter is absent and stall_cnt_o is tied to 0.
  - The port remains, so the top-level wiring is identical.

## Structure
- hazard_pkg holds:
  - lat_class_e (ALU=2'd0, LOAD=2'd1, LONG=2'd2; 2'd3 is treated as ALU);
  - the NUM_REGS=32 constant.
- Sub-module sb_reg_entry, instantiated once for each register x1..x31. It holds cnt and busy, with load/set/clear/decrement inputs and a not_ready output.
- The top level holds the x0 masking, the stall muxing, long_cnt, err_o and the stats counter.

## Test plan
- LOAD x5, then ADD x6,x5,x1 issued the next cycle: stall_o=1 for 1 cycle, then issue_ok_o=1. Repeat with LOAD_LAT=2: 2 stall cycles.
- ALU write to x7, then a dependent reader of x7 the next cycle: stall_o=0 and no stall.
- LONG to x9, reader of x9 waiting: stall_o=1 until done_valid_i(rd=9) in cycle N, then issue_ok_o=1 in N+1.
- MAX_LONG=2, LONG ops to x1 and x2 outstanding, a third LONG issued: stall_o=1. A done(rd=1) in the same cycle lets it issue.
- ALU write to x3 while busy[3]=1: WAW stall until the done. A done for x4 with busy[4]=0 sets err_o, which persists until reset.
- Assert rst_ni low while a load stall and two LONG ops are pending: all state clears and stall_o=0 the next cycle. With the macro defined, stall_cnt_o=0.
